// File: rtl/round_judge.sv
// Round adjudication and scoring engine for the choice-battle game.
// Latches both one-hot choices on a rising choose edge, judges the round by cyclic dominance,
// drives the one-hot scenario vector, and keeps saturating scores up to WIN_SCORE.
// Build option: define ROUND_JUDGE_STRICT_EN to reject rounds with non-one-hot choices
// (choice_err pulses). Without it, choice_err is tied 0 and an invalid choice counts as index 0.
module round_judge #(
    parameter int unsigned NUM_CHOICES = 3,
    parameter int unsigned SCORE_W     = 4,
    parameter int unsigned WIN_SCORE   = 9
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               new_game,
    input  logic                               choose,
    input  logic                               cont,
    input  logic [NUM_CHOICES-1:0]             p1_choice,
    input  logic [NUM_CHOICES-1:0]             p2_choice,
    output logic [NUM_CHOICES*NUM_CHOICES-1:0] scenario,
    output logic                               winner1,
    output logic                               winner2,
    output logic [SCORE_W-1:0]                 score1,
    output logic [SCORE_W-1:0]                 score2,
    output logic                               result_valid,
    output logic                               match_over,
    output logic                               choice_err
);

    localparam int unsigned IDX_W  = $clog2(NUM_CHOICES);
    localparam int unsigned D_W    = IDX_W + 1;
    localparam int unsigned SCEN_W = NUM_CHOICES * NUM_CHOICES;
    localparam logic [D_W-1:0]     N_D    = D_W'(NUM_CHOICES);
    localparam logic [D_W-1:0]     HALF_D = D_W'((NUM_CHOICES - 1) / 2);
    localparam logic [SCORE_W-1:0] WIN    = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {StIdle, StJudge, StResult, StOver} state_e;

    state_e              state_q, state_d;
    logic                choose_q;
    logic [NUM_CHOICES-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [SCEN_W-1:0]   scen_q, scen_d;
    logic                w1_q, w1_d, w2_q, w2_d;
    logic [SCORE_W-1:0]  score1_q, score1_d, score2_q, score2_d;

    logic                rise;
    logic                choices_ok;
    logic [IDX_W-1:0]    i_idx, j_idx;
    logic [D_W-1:0]      sum, d;
    logic                p1_wins, p2_wins;
    logic [SCEN_W-1:0]   scen_onehot;

    function automatic logic is_onehot(input logic [NUM_CHOICES-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int k = 0; k < NUM_CHOICES; k++) begin
            if (v[k]) cnt++;
        end
        return cnt == 1;
    endfunction

    // Invalid vectors encode to index 0 (cat in the three-choice game).
    function automatic logic [IDX_W-1:0] encode(input logic [NUM_CHOICES-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_CHOICES; k++) begin
            if (v[k]) idx = IDX_W'(k);
        end
        return is_onehot(v) ? idx : '0;
    endfunction

    assign rise = choose & ~choose_q;

`ifdef ROUND_JUDGE_STRICT_EN
    assign choices_ok = is_onehot(p1_choice) && is_onehot(p2_choice);
`else
    assign choices_ok = 1'b1;
`endif

    // Judge the latched round: cyclic distance d = (i - j) mod N decides the winner.
    always_comb begin
        i_idx       = encode(p1_q);
        j_idx       = encode(p2_q);
        sum         = {1'b0, i_idx} + N_D - {1'b0, j_idx};
        d           = (sum >= N_D) ? sum - N_D : sum;
        p1_wins     = (d != '0) && (d <= HALF_D);
        p2_wins     = (d != '0) && !p1_wins;
        scen_onehot = {{(SCEN_W-1){1'b0}}, 1'b1} << (NUM_CHOICES * 32'(i_idx) + 32'(j_idx));
    end

    // Next-state and datapath update; new_game overrides everything.
    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        scen_d   = scen_q;
        w1_d     = w1_q;
        w2_d     = w2_q;
        score1_d = score1_q;
        score2_d = score2_q;
        if (new_game) begin
            state_d  = StIdle;
            scen_d   = '0;
            w1_d     = 1'b0;
            w2_d     = 1'b0;
            score1_d = '0;
            score2_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (rise && choices_ok) begin
                        p1_d    = p1_choice;
                        p2_d    = p2_choice;
                        state_d = StJudge;
                    end
                end
                StJudge: begin
                    scen_d  = scen_onehot;
                    w1_d    = p1_wins;
                    w2_d    = p2_wins;
                    state_d = StResult;
                    if (p1_wins) begin
                        if (score1_q < WIN) score1_d = score1_q + 1'b1;
                        if (score1_d == WIN) state_d = StOver;
                    end
                    if (p2_wins) begin
                        if (score2_q < WIN) score2_d = score2_q + 1'b1;
                        if (score2_d == WIN) state_d = StOver;
                    end
                end
                StResult: begin
                    if (cont) begin
                        w1_d    = 1'b0;
                        w2_d    = 1'b0;
                        state_d = StIdle;
                    end
                end
                StOver: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            choose_q <= 1'b0;
            p1_q     <= '0;
            p2_q     <= '0;
            scen_q   <= '0;
            w1_q     <= 1'b0;
            w2_q     <= 1'b0;
            score1_q <= '0;
            score2_q <= '0;
        end else begin
            state_q  <= state_d;
            choose_q <= choose;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            scen_q   <= scen_d;
            w1_q     <= w1_d;
            w2_q     <= w2_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
        end
    end

`ifdef ROUND_JUDGE_STRICT_EN
    logic err_q;

    // One-cycle error pulse for a rejected round.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= !new_game && (state_q == StIdle) && rise && !choices_ok;
        end
    end

    assign choice_err = err_q;
`else
    assign choice_err = 1'b0;
`endif

    assign scenario     = scen_q;
    assign winner1      = w1_q;
    assign winner2      = w2_q;
    assign score1       = score1_q;
    assign score2       = score2_q;
    assign result_valid = (state_q == StResult) || (state_q == StOver);
    assign match_over   = (state_q == StOver);

endmodule

// File: tb/tb_round_judge.sv
// Bench for round_judge: a 3-choice instance (WIN_SCORE=3) checked through an expectation
// queue, plus a 5-choice instance exercising the cyclic-dominance boundaries.
module tb_round_judge;

    logic clk = 1'b0;
    logic resetn, new_game, choose, cont, choose5;
    logic [2:0] p1, p2;
    logic [4:0] p1_5, p2_5;
    logic [8:0] scen;
    logic w1, w2, rv, mo, err;
    logic [3:0] s1, s2;
    logic [24:0] scen5;
    logic w1_5, w2_5, rv5, mo5, err5;
    logic [3:0] s1_5, s2_5;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [8:0] scen;
        logic       w1;
        logic       w2;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       mo;
    } exp_t;

    exp_t exp_q[$];
    int   m_s1, m_s2, m5_1, m5_2;
    logic rv_prev;

    always #5 clk = ~clk;

    round_judge #(.NUM_CHOICES(3), .SCORE_W(4), .WIN_SCORE(3)) u_dut3 (
        .clk(clk), .resetn(resetn), .new_game(new_game), .choose(choose), .cont(cont),
        .p1_choice(p1), .p2_choice(p2), .scenario(scen), .winner1(w1), .winner2(w2),
        .score1(s1), .score2(s2), .result_valid(rv), .match_over(mo), .choice_err(err)
    );

    round_judge #(.NUM_CHOICES(5), .SCORE_W(4), .WIN_SCORE(9)) u_dut5 (
        .clk(clk), .resetn(resetn), .new_game(new_game), .choose(choose5), .cont(cont),
        .p1_choice(p1_5), .p2_choice(p2_5), .scenario(scen5), .winner1(w1_5),
        .winner2(w2_5), .score1(s1_5), .score2(s2_5), .result_valid(rv5),
        .match_over(mo5), .choice_err(err5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx3(input logic [2:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 0;
        endcase
    endfunction

    // Expected outcome of a 3-choice round: dog>cat, chicken>dog, cat>chicken.
    task automatic push3(input logic [2:0] a, input logic [2:0] b);
        exp_t e;
        logic [8:0] one9;
        int i, j;
        logic win1, win2;
        one9 = 9'd1;
        i = idx3(a);
        j = idx3(b);
        win1 = (i == 1 && j == 0) || (i == 2 && j == 1) || (i == 0 && j == 2);
        win2 = (i != j) && !win1;
        if (win1 && m_s1 < 3) m_s1++;
        if (win2 && m_s2 < 3) m_s2++;
        e.scen = one9 << (i * 3 + j);
        e.w1   = win1;
        e.w2   = win2;
        e.s1   = 4'(m_s1);
        e.s2   = 4'(m_s2);
        e.mo   = (m_s1 == 3) || (m_s2 == 3);
        exp_q.push_back(e);
    endtask

    // Compare each new result against the oldest queued expectation.
    always @(negedge clk) begin
        if (!resetn) begin
            rv_prev <= 1'b0;
        end else begin
            if (rv && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    check("spurious_result", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("scenario", 32'(scen), 32'(e.scen));
                    check("winner1", 32'(w1), 32'(e.w1));
                    check("winner2", 32'(w2), 32'(e.w2));
                    check("score1", 32'(s1), 32'(e.s1));
                    check("score2", 32'(s2), 32'(e.s2));
                    check("match_over", 32'(mo), 32'(e.mo));
                end
            end
            rv_prev <= rv;
        end
    end

    task automatic round3(input logic [2:0] a, input logic [2:0] b, input bit hold);
        int k;
        p1 = a;
        p2 = b;
        choose = 1'b1;
        push3(a, b);
        tick();
        p1 = ~a;
        p2 = ~b;
        if (!hold) choose = 1'b0;
        tick();
        check("rv_after_2_edges", 32'(rv), 32'd1);
        k = 0;
        while (exp_q.size() != 0 && k < 8) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("result_seen", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic cont_pulse();
        cont = 1'b1;
        tick();
        cont = 1'b0;
        check("rv_after_cont", 32'(rv), 32'd0);
    endtask

    function automatic int idx5(input logic [4:0] v);
        for (int k = 0; k < 5; k++) begin
            if (v[k]) return k;
        end
        return 0;
    endfunction

    task automatic round5(input logic [4:0] a, input logic [4:0] b);
        logic [24:0] one25;
        int i, j;
        logic win1, win2;
        one25 = 25'd1;
        i = idx5(a);
        j = idx5(b);
        win1 = ((j + 1) % 5 == i) || ((j + 2) % 5 == i);
        win2 = (i != j) && !win1;
        if (win1) m5_1++;
        if (win2) m5_2++;
        p1_5 = a;
        p2_5 = b;
        choose5 = 1'b1;
        tick();
        choose5 = 1'b0;
        tick();
        check("n5_rv", 32'(rv5), 32'd1);
        check("n5_scenario", 32'(scen5), 32'(one25 << (i * 5 + j)));
        check("n5_winner1", 32'(w1_5), 32'(win1));
        check("n5_winner2", 32'(w2_5), 32'(win2));
        check("n5_score1", 32'(s1_5), 32'(m5_1));
        check("n5_score2", 32'(s2_5), 32'(m5_2));
        cont = 1'b1;
        tick();
        cont = 1'b0;
        check("n5_rv_after_cont", 32'(rv5), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; new_game = 1'b0; choose = 1'b0; cont = 1'b0; choose5 = 1'b0;
        p1 = '0; p2 = '0; p1_5 = '0; p2_5 = '0;
        m_s1 = 0; m_s2 = 0; m5_1 = 0; m5_2 = 0;
        #12;
        resetn = 1'b1;
        tick();
        tick();
        check("rst_scenario", 32'(scen), 32'd0);
        check("rst_winners", 32'({w1, w2}), 32'd0);
        check("rst_scores", 32'({s1, s2}), 32'd0);
        check("rst_rv", 32'(rv), 32'd0);
        check("rst_match_over", 32'(mo), 32'd0);
        check("rst_choice_err", 32'(err), 32'd0);

        // cat vs dog: dog wins.
        round3(3'b001, 3'b010, 1'b0);
        cont_pulse();
        check("w2_cleared", 32'(w2), 32'd0);
        check("scen_holds", 32'(scen), 32'h002);

        // Tie chicken vs chicken.
        round3(3'b100, 3'b100, 1'b0);
        cont_pulse();

        // choose held high through the round and back into IDLE.
        round3(3'b010, 3'b001, 1'b1);
        cont_pulse();
        repeat (4) tick();
        check("no_second_round", 32'(rv), 32'd0);
        check("score1_held", 32'(s1), 32'd1);
        choose = 1'b0;
        tick();
        round3(3'b100, 3'b010, 1'b0);

        // A choose edge on the same cycle as cont is ignored.
        choose = 1'b1;
        cont = 1'b1;
        tick();
        cont = 1'b0;
        repeat (3) tick();
        check("choose_with_cont_ignored", 32'(rv), 32'd0);
        choose = 1'b0;
        tick();

`ifdef ROUND_JUDGE_STRICT_EN
        p1 = 3'b011;
        p2 = 3'b001;
        choose = 1'b1;
        tick();
        choose = 1'b0;
        check("choice_err_pulse", 32'(err), 32'd1);
        tick();
        check("choice_err_single", 32'(err), 32'd0);
        tick();
        check("invalid_stays_idle", 32'(rv), 32'd0);
        check("invalid_scores", 32'({s1, s2}), 32'h21);
`else
        round3(3'b011, 3'b001, 1'b0);
        check("choice_err_tied", 32'(err), 32'd0);
        cont_pulse();
`endif

        // Third p1 win ends the match.
        round3(3'b100, 3'b010, 1'b0);
        choose = 1'b0;
        tick();
        p1 = 3'b001;
        p2 = 3'b010;
        choose = 1'b1;
        cont = 1'b1;
        repeat (3) tick();
        choose = 1'b0;
        cont = 1'b0;
        tick();
        check("over_match_over", 32'(mo), 32'd1);
        check("over_rv", 32'(rv), 32'd1);
        check("over_scores", 32'({s1, s2}), 32'h31);
        check("over_winner1", 32'(w1), 32'd1);

        // new_game beats a simultaneous choose edge; held choose never retriggers.
        new_game = 1'b1;
        choose = 1'b1;
        tick();
        new_game = 1'b0;
        m_s1 = 0;
        m_s2 = 0;
        repeat (3) tick();
        check("ng_scores", 32'({s1, s2}), 32'd0);
        check("ng_rv", 32'(rv), 32'd0);
        check("ng_match_over", 32'(mo), 32'd0);
        check("ng_scenario", 32'(scen), 32'd0);
        check("ng_winners", 32'({w1, w2}), 32'd0);
        choose = 1'b0;
        tick();

        // Asynchronous reset while a result is displayed.
        round3(3'b001, 3'b100, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check("async_score1", 32'(s1), 32'd0);
        check("async_rv", 32'(rv), 32'd0);
        check("async_scenario", 32'(scen), 32'd0);
        check("async_winner1", 32'(w1), 32'd0);
        m_s1 = 0;
        m_s2 = 0;
        tick();
        resetn = 1'b1;
        tick();

        // Five choices: distances 2, 3, 4 and both orderings.
        round5(5'b01000, 5'b00010);
        round5(5'b00010, 5'b01000);
        round5(5'b00100, 5'b00001);
        round5(5'b00001, 5'b00100);
        round5(5'b10000, 5'b00001);
        round5(5'b00100, 5'b00100);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
